// File: rtl/hamming_encoder_serializer.sv
// Hamming(7,4) encoder with a MSB-first serializer and a one-entry pending buffer.
// Codeword layout is {d3,d2,d1,p2,d0,p1,p0}, matching the team's serial decoder.
module hamming_encoder_serializer #(
  parameter int   WIDTH_PISO = 4,
  parameter int   WIDTH_SIPO = 7,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_PISO-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  err_inject,
  input  logic [2:0]            err_pos,
  output logic                  serial_out,
  output logic                  serial_valid,
  output logic                  frame_start,
  output logic [WIDTH_SIPO-1:0] codeword_out,
  output logic                  busy
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                state, state_n;
  logic [2:0]            cnt, cnt_n;
  logic [WIDTH_SIPO-1:0] codeword_n;
  logic                  serial_out_n, serial_valid_n, frame_start_n;
  logic                  pend_full, pend_full_n;
  logic [WIDTH_SIPO-1:0] pend_word, pend_word_n;
  logic [WIDTH_SIPO-1:0] raw_word, flip_mask, enc_word;
  logic                  p0, p1, p2;
  logic                  xfer;

  assign p0 = data_in[0] ^ data_in[1] ^ data_in[3];
  assign p1 = data_in[0] ^ data_in[2] ^ data_in[3];
  assign p2 = data_in[1] ^ data_in[2] ^ data_in[3];

  assign raw_word  = {data_in[3], data_in[2], data_in[1], p2, data_in[0], p1, p0};
  // err_pos of 7 falls outside the codeword and deliberately flips nothing
  assign flip_mask = (err_inject && (err_pos != 3'd7)) ? (WIDTH_SIPO'(1) << err_pos) : '0;
  assign enc_word  = raw_word ^ flip_mask;

  assign data_ready = ~pend_full & ~rst;
  assign xfer       = data_valid & data_ready;
  assign busy       = (state == SHIFT) | pend_full;

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    codeword_n     = codeword_out;
    serial_out_n   = IDLE_LEVEL;
    serial_valid_n = 1'b0;
    frame_start_n  = 1'b0;
    pend_full_n    = pend_full;
    pend_word_n    = pend_word;

    case (state)
      IDLE: begin
        if (xfer) begin
          state_n        = SHIFT;
          cnt_n          = 3'd6;
          codeword_n     = enc_word;
          serial_out_n   = enc_word[6];
          serial_valid_n = 1'b1;
          frame_start_n  = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt != 3'd0) begin
          cnt_n          = cnt - 3'd1;
          serial_out_n   = codeword_out[cnt - 3'd1];
          serial_valid_n = 1'b1;
          if (xfer) begin
            pend_full_n = 1'b1;
            pend_word_n = enc_word;
          end
        end else if (pend_full) begin
          // Pending word goes straight out so frames abut with no idle bit
          cnt_n          = 3'd6;
          codeword_n     = pend_word;
          serial_out_n   = pend_word[6];
          serial_valid_n = 1'b1;
          frame_start_n  = 1'b1;
          pend_full_n    = 1'b0;
        end else if (xfer) begin
          cnt_n          = 3'd6;
          codeword_n     = enc_word;
          serial_out_n   = enc_word[6];
          serial_valid_n = 1'b1;
          frame_start_n  = 1'b1;
        end else begin
          state_n = IDLE;
          cnt_n   = 3'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      codeword_out <= '0;
      serial_out   <= IDLE_LEVEL;
      serial_valid <= 1'b0;
      frame_start  <= 1'b0;
      pend_full    <= 1'b0;
      pend_word    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      codeword_out <= codeword_n;
      serial_out   <= serial_out_n;
      serial_valid <= serial_valid_n;
      frame_start  <= frame_start_n;
      pend_full    <= pend_full_n;
      pend_word    <= pend_word_n;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_serializer.sv
// Bench for hamming_encoder_serializer: table vectors, streaming, mid-frame reset,
// and a behavioural Hamming decoder fed from the serial stream.
module tb_hamming_encoder_serializer;

  localparam logic IDLE_LEVEL = 1'b0;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       err_inject;
  logic [2:0] err_pos;
  logic       serial_out;
  logic       serial_valid;
  logic       frame_start;
  logic [6:0] codeword_out;
  logic       busy;

  hamming_encoder_serializer #(
    .WIDTH_PISO(4),
    .WIDTH_SIPO(7),
    .IDLE_LEVEL(IDLE_LEVEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .err_inject(err_inject),
    .err_pos(err_pos),
    .serial_out(serial_out),
    .serial_valid(serial_valid),
    .frame_start(frame_start),
    .codeword_out(codeword_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       inj;
    logic [2:0] pos;
    logic [6:0] cw;
  } vec_t;

  vec_t       vecs[6];
  int         tests_run = 0;
  int         fails = 0;
  logic [6:0] exp_cw_q[$];
  logic [3:0] exp_data_q[$];
  int         bit_idx = 0;
  int         run_len = 0;
  int         max_run = 0;
  logic [6:0] frame_bits = '0;
  logic [6:0] mon_cw;
  logic [3:0] mon_data;
  int         waited;

  function automatic logic [6:0] model_enc(input logic [3:0] d, input logic inj, input logic [2:0] pos);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
    if (inj && pos != 3'd7) c[pos] = ~c[pos];
    return c;
  endfunction

  // Standard Hamming(7,4): codeword bit i sits at Hamming position i+1
  function automatic logic [3:0] model_dec(input logic [6:0] cin);
    logic [6:0] c;
    logic [2:0] s;
    c = cin;
    s = {c[3] ^ c[4] ^ c[5] ^ c[6], c[1] ^ c[2] ^ c[5] ^ c[6], c[0] ^ c[2] ^ c[4] ^ c[6]};
    if (s != 3'd0) c[s - 3'd1] = ~c[s - 3'd1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  task automatic checkOutput(input string name, input logic [6:0] actual, input logic [6:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] d, input logic inj, input logic [2:0] pos,
                               input logic [6:0] cw, output int wait_cycles);
    data_in     = d;
    err_inject  = inj;
    err_pos     = pos;
    data_valid  = 1'b1;
    wait_cycles = 0;
    while (!data_ready && wait_cycles < 200) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!data_ready) begin
      tests_run++;
      fails++;
      $display("[TB] FAIL handshake_timeout: data_ready stayed low for %0d cycles", wait_cycles);
    end else begin
      exp_cw_q.push_back(cw);
      exp_data_q.push_back(d);
      @(negedge clk);
    end
    data_valid = 1'b0;
  endtask

  task automatic waitDrained();
    int n;
    n = 0;
    while ((exp_cw_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_in_time", 7'(n < 2000), 7'd1);
  endtask

  // Monitor: reassemble frames from the serial stream and score them
  always @(negedge clk) begin
    if (rst) begin
      bit_idx = 0;
      run_len = 0;
    end else if (serial_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      checkOutput("frame_start", 7'(frame_start), 7'(bit_idx == 0));
      frame_bits = {frame_bits[5:0], serial_out};
      bit_idx++;
      if (bit_idx == 7) begin
        bit_idx = 0;
        if (exp_cw_q.size() == 0) begin
          tests_run++;
          fails++;
          $display("[TB] FAIL unexpected_frame: got %b, expected no frame", frame_bits);
        end else begin
          mon_cw   = exp_cw_q.pop_front();
          mon_data = exp_data_q.pop_front();
          checkOutput("serial_codeword", frame_bits, mon_cw);
          checkOutput("codeword_out", codeword_out, mon_cw);
          checkOutput("decoded_data", 7'(model_dec(frame_bits)), 7'(mon_data));
        end
      end
    end else begin
      run_len = 0;
      checkOutput("frame_gap", 7'(bit_idx), 7'd0);
      checkOutput("idle_serial_out", 7'(serial_out), 7'(IDLE_LEVEL));
      checkOutput("idle_frame_start", 7'(frame_start), 7'd0);
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{4'b1011, 1'b0, 3'd0, 7'b1010101};
    vecs[1] = '{4'b0000, 1'b0, 3'd0, 7'b0000000};
    vecs[2] = '{4'b1111, 1'b0, 3'd0, 7'b1111111};
    vecs[3] = '{4'b0001, 1'b0, 3'd0, 7'b0000111};
    vecs[4] = '{4'b1011, 1'b1, 3'd4, 7'b1000101};
    vecs[5] = '{4'b1011, 1'b1, 3'd7, 7'b1010101};

    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    err_inject = 1'b0;
    err_pos    = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_serial_out", 7'(serial_out), 7'(IDLE_LEVEL));
    checkOutput("reset_serial_valid", 7'(serial_valid), 7'd0);
    checkOutput("reset_codeword_out", codeword_out, 7'd0);
    checkOutput("reset_busy", 7'(busy), 7'd0);
    checkOutput("reset_data_ready", 7'(data_ready), 7'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready_after_reset", 7'(data_ready), 7'd1);

    // Single frames from the table, each followed by a return to idle
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].data, vecs[i].inj, vecs[i].pos, vecs[i].cw, waited);
      checkOutput("first_bit_valid", 7'(serial_valid), 7'd1);
      checkOutput("first_bit_start", 7'(frame_start), 7'd1);
      checkOutput("first_bit_value", 7'(serial_out), 7'(vecs[i].cw[6]));
      waitDrained();
      checkOutput("hold_codeword", codeword_out, vecs[i].cw);
      checkOutput("idle_valid", 7'(serial_valid), 7'd0);
      checkOutput("idle_busy", 7'(busy), 7'd0);
    end

    // Back-to-back stream: pending buffer fills, frames abut
    max_run = 0;
    applyStimulus(4'b0001, 1'b0, 3'd0, 7'b0000111, waited);
    applyStimulus(4'b1011, 1'b0, 3'd0, 7'b1010101, waited);
    checkOutput("pend_full_ready", 7'(data_ready), 7'd0);
    checkOutput("pend_full_busy", 7'(busy), 7'd1);
    applyStimulus(4'b1111, 1'b0, 3'd0, 7'b1111111, waited);
    checkOutput("pend_wait_cycles", 7'(waited), 7'd6);
    waitDrained();
    checkOutput("stream_run_length", 7'(max_run), 7'd21);

    // Reset on the third bit of a frame with a word pending
    applyStimulus(4'b1011, 1'b0, 3'd0, 7'b1010101, waited);
    applyStimulus(4'b0001, 1'b0, 3'd0, 7'b0000111, waited);
    @(negedge clk);
    #1;
    rst = 1'b1;
    exp_cw_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    checkOutput("midrst_serial_out", 7'(serial_out), 7'(IDLE_LEVEL));
    checkOutput("midrst_serial_valid", 7'(serial_valid), 7'd0);
    checkOutput("midrst_frame_start", 7'(frame_start), 7'd0);
    checkOutput("midrst_codeword_out", codeword_out, 7'd0);
    checkOutput("midrst_busy", 7'(busy), 7'd0);
    checkOutput("midrst_data_ready", 7'(data_ready), 7'd0);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("midrst_ready_after", 7'(data_ready), 7'd1);
    @(negedge clk);
    applyStimulus(4'b0110, 1'b0, 3'd0, model_enc(4'b0110, 1'b0, 3'd0), waited);
    checkOutput("clean_frame_start", 7'(frame_start), 7'd1);
    waitDrained();

    // Loopback: every data word with every single-bit error position, streamed
    for (int d = 0; d < 16; d++) begin
      for (int p = 0; p < 7; p++) begin
        applyStimulus(4'(d), 1'b1, 3'(p), model_enc(4'(d), 1'b1, 3'(p)), waited);
      end
    end
    waitDrained();

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
